// File: rtl/avr_pkg.sv
// Shared definitions for the timer interrupt controller: FSM states,
// vector table defaults, TIFR bit positions and small helpers.
package avr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PUSH_L,
        ST_PUSH_H,
        ST_JUMP,
        ST_POP_H,
        ST_POP_L,
        ST_POP_W,
        ST_RET
    } irq_state_e;

    localparam logic [13:0] VEC_BASE_DEFAULT = 14'h006;
    localparam logic [13:0] VEC_STEP_DEFAULT = 14'h002;

    localparam int unsigned TIFR_OCF2  = 7;
    localparam int unsigned TIFR_TOV2  = 6;
    localparam int unsigned TIFR_ICF1  = 5;
    localparam int unsigned TIFR_OCF1A = 4;
    localparam int unsigned TIFR_OCF1B = 3;
    localparam int unsigned TIFR_TOV1  = 2;
    localparam int unsigned TIFR_OCF0  = 1;
    localparam int unsigned TIFR_TOV0  = 0;

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'b0000_0001 << idx;
    endfunction

    // Bit 7 owns the first vector; lower bits follow at VEC_STEP spacing.
    function automatic logic [13:0] vector_addr(input logic [13:0] base,
                                                input logic [13:0] step,
                                                input logic [2:0]  idx);
        logic [13:0] rank;
        rank = {11'd0, 3'd7 - idx};
        return base + rank * step;
    endfunction

endpackage

// File: rtl/irq_priority_encoder.sv
// Picks the highest set bit of the pending mask (bit 7 wins).
module irq_priority_encoder
    import avr_pkg::*;
(
    input  logic [7:0] i_pending,
    output logic       o_valid,
    output logic [2:0] o_idx
);

    always_comb begin
        o_idx = '0;
        for (int unsigned i = TIFR_TOV0; i <= TIFR_OCF2; i++) begin
            if (i_pending[i]) begin
                o_idx = 3'(i);
            end
        end
    end

    assign o_valid = |i_pending;

endmodule

// File: rtl/interrupt_controller.sv
// Timer interrupt entry/return sequencer: pushes the return PC, jumps to the
// vector, and on RETI pops the PC back and restores the global enable.
module interrupt_controller
    import avr_pkg::*;
#(
    parameter logic [13:0] VEC_BASE = VEC_BASE_DEFAULT,
    parameter logic [13:0] VEC_STEP = VEC_STEP_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  tifr,
    input  logic [7:0]  timsk,
    input  logic        sreg_i,
    input  logic        instr_boundary,
    input  logic        reti,
    input  logic [13:0] pc,
    input  logic [15:0] sp,
    input  logic [7:0]  mem_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    output logic        sp_we,
    output logic [15:0] sp_new,
    output logic        hold,
    output logic        pc_overwrite,
    output logic [13:0] pc_new,
    output logic [7:0]  tifr_clear,
    output logic        sreg_i_clear,
    output logic        sreg_i_set,
    output logic        busy
);

    irq_state_e  r_state;
    irq_state_e  w_next;
    logic [13:0] r_pc_l;
    logic [15:0] r_sp_l;
    logic [2:0]  r_idx;
    logic [5:0]  r_hi;
    logic [7:0]  r_lo;
    logic        r_guard;

    logic [7:0]  w_pending;
    logic        w_valid;
    logic [2:0]  w_idx;
    logic        w_take_reti;
    logic        w_take_irq;
    logic [13:0] w_vector;

    assign w_pending = tifr & timsk;
    assign w_vector  = vector_addr(VEC_BASE, VEC_STEP, r_idx);

    irq_priority_encoder u_prio (
        .i_pending (w_pending),
        .o_valid   (w_valid),
        .o_idx     (w_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_pc_l  <= '0;
            r_sp_l  <= '0;
            r_idx   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_guard <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    // Any boundary retires the post-RETI instruction; entry
                    // below still sees the old guard for this boundary.
                    if (instr_boundary) begin
                        r_guard <= 1'b0;
                    end
                    if (w_take_irq) begin
                        r_pc_l <= pc;
                        r_sp_l <= sp;
                        r_idx  <= w_idx;
                    end
                    if (w_take_reti) begin
                        r_sp_l <= sp;
                    end
                end
                ST_POP_L: r_hi    <= mem_rdata[5:0];
                ST_POP_W: r_lo    <= mem_rdata;
                ST_RET:   r_guard <= 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next       = r_state;
        w_take_reti  = 1'b0;
        w_take_irq   = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        sp_we        = 1'b0;
        sp_new       = '0;
        pc_overwrite = 1'b0;
        pc_new       = '0;
        tifr_clear   = '0;
        sreg_i_clear = 1'b0;
        sreg_i_set   = 1'b0;
        busy         = 1'b0;
        hold         = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (instr_boundary && reti) begin
                    w_take_reti = 1'b1;
                    w_next      = ST_POP_H;
                end else if (instr_boundary && sreg_i && w_valid && !r_guard) begin
                    w_take_irq = 1'b1;
                    w_next     = ST_PUSH_L;
                end
            end
            ST_PUSH_L: w_next = ST_PUSH_H;
            ST_PUSH_H: w_next = ST_JUMP;
            ST_JUMP:   w_next = ST_IDLE;
            ST_POP_H:  w_next = ST_POP_L;
            ST_POP_L:  w_next = ST_POP_W;
            ST_POP_W:  w_next = ST_RET;
            ST_RET:    w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase

        // Outputs are masked while rst is high so an interrupted sequence
        // never emits a partial stack or flag-clear pulse.
        if (!rst) begin
            busy = (r_state != ST_IDLE);
            hold = busy;
            case (r_state)
                ST_PUSH_L: begin
                    mem_addr  = r_sp_l;
                    mem_wdata = r_pc_l[7:0];
                    mem_we    = 1'b1;
                end
                ST_PUSH_H: begin
                    mem_addr  = r_sp_l - 16'd1;
                    mem_wdata = {2'b00, r_pc_l[13:8]};
                    mem_we    = 1'b1;
                    sp_we     = 1'b1;
                    sp_new    = r_sp_l - 16'd2;
                end
                ST_JUMP: begin
                    pc_overwrite = 1'b1;
                    pc_new       = w_vector;
                    tifr_clear   = onehot8(r_idx);
                    sreg_i_clear = 1'b1;
                end
                ST_POP_H: begin
                    mem_addr = r_sp_l + 16'd1;
                    mem_re   = 1'b1;
                end
                ST_POP_L: begin
                    mem_addr = r_sp_l + 16'd2;
                    mem_re   = 1'b1;
                end
                ST_RET: begin
                    pc_overwrite = 1'b1;
                    pc_new       = {r_hi, r_lo};
                    sp_we        = 1'b1;
                    sp_new       = r_sp_l + 16'd2;
                    sreg_i_set   = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller with a byte-wide data memory model.
module tb_interrupt_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  tifr;
    logic [7:0]  timsk;
    logic        sreg_i;
    logic        instr_boundary;
    logic        reti;
    logic [13:0] pc;
    logic [15:0] sp;
    logic [7:0]  mem_rdata = 8'h00;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic        sp_we;
    logic [15:0] sp_new;
    logic        hold;
    logic        pc_overwrite;
    logic [13:0] pc_new;
    logic [7:0]  tifr_clear;
    logic        sreg_i_clear;
    logic        sreg_i_set;
    logic        busy;

    logic [7:0]  mem [0:65535];
    logic        preload;
    logic [69:0] all_outs;
    int          n_assert = 0;
    int          n_fail   = 0;

    interrupt_controller #(
        .VEC_BASE (14'h006),
        .VEC_STEP (14'h002)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .tifr           (tifr),
        .timsk          (timsk),
        .sreg_i         (sreg_i),
        .instr_boundary (instr_boundary),
        .reti           (reti),
        .pc             (pc),
        .sp             (sp),
        .mem_rdata      (mem_rdata),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_we         (mem_we),
        .mem_re         (mem_re),
        .sp_we          (sp_we),
        .sp_new         (sp_new),
        .hold           (hold),
        .pc_overwrite   (pc_overwrite),
        .pc_new         (pc_new),
        .tifr_clear     (tifr_clear),
        .sreg_i_clear   (sreg_i_clear),
        .sreg_i_set     (sreg_i_set),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    assign all_outs = {mem_addr, mem_wdata, mem_we, mem_re, sp_we, sp_new, hold,
                       pc_overwrite, pc_new, tifr_clear, sreg_i_clear, sreg_i_set, busy};

    // Synchronous RAM: writes on the edge, read data one cycle after mem_re.
    always @(posedge clk) begin
        if (preload) mem[16'h0001] <= 8'h34;
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_boundary(input logic is_reti);
        instr_boundary = 1'b1;
        reti = is_reti;
        tick();
        instr_boundary = 1'b0;
        reti = 1'b0;
    endtask

    initial begin
        rst = 1'b1; preload = 1'b1;
        tifr = '0; timsk = '0; sreg_i = 1'b0; instr_boundary = 1'b0; reti = 1'b0;
        pc = '0; sp = '0;
        tick(); tick();
        chk("reset_outputs", all_outs, 70'd0);
        rst = 1'b0; preload = 1'b0;
        tick();
        chk("idle_after_reset", {busy, hold}, 2'b00);

        // Basic entry: TOV0, pc 0x0123, sp 0x085F
        tifr = 8'h01; timsk = 8'h01; sreg_i = 1'b1; pc = 14'h0123; sp = 16'h085F;
        pulse_boundary(1'b0);
        chk("A_pushl_busy", {busy, hold, pc_overwrite}, 3'b110);
        chk("A_pushl", {mem_addr, mem_wdata, mem_we, sp_we}, {16'h085F, 8'h23, 1'b1, 1'b0});
        tick();
        chk("A_pushh", {mem_addr, mem_wdata, mem_we, sp_we, sp_new},
            {16'h085E, 8'h01, 1'b1, 1'b1, 16'h085D});
        tick();
        chk("A_jump", {pc_overwrite, pc_new, tifr_clear, sreg_i_clear, sreg_i_set, mem_we},
            {1'b1, 14'h014, 8'h01, 1'b1, 1'b0, 1'b0});
        chk("A_stack_mem", {mem[16'h085F], mem[16'h085E]}, 16'h2301);
        tifr = 8'h00; sreg_i = 1'b0;
        tick();
        chk("A_back_idle", {busy, hold, pc_overwrite}, 3'b000);

        // No action when masked or globally disabled
        tifr = 8'h01; timsk = 8'h00; sreg_i = 1'b1;
        pulse_boundary(1'b0);
        chk("masked_no_entry", {busy, mem_we, pc_overwrite}, 3'b000);
        timsk = 8'h01; sreg_i = 1'b0;
        pulse_boundary(1'b0);
        chk("sregi0_no_entry", {busy, mem_we, pc_overwrite}, 3'b000);
        tifr = 8'h00;

        // Return from the handler
        sp = 16'h085D;
        pulse_boundary(1'b1);
        chk("A_poph", {mem_addr, mem_re, mem_we}, {16'h085E, 1'b1, 1'b0});
        tick();
        chk("A_popl", {mem_addr, mem_re}, {16'h085F, 1'b1});
        tick();
        chk("A_popw", {busy, hold, mem_re, pc_overwrite}, 4'b1100);
        tick();
        chk("A_ret", {pc_overwrite, pc_new, sp_we, sp_new, sreg_i_set, sreg_i_clear},
            {1'b1, 14'h0123, 1'b1, 16'h085F, 1'b1, 1'b0});
        tick();
        chk("A_ret_idle", busy, 1'b0);
        pulse_boundary(1'b0);

        // Priority, latched idx despite flag/mask changes during entry
        tifr = 8'h12; timsk = 8'hFF; sreg_i = 1'b1; pc = 14'h0200; sp = 16'h0100;
        pulse_boundary(1'b0);
        tifr = 8'h92; timsk = 8'h80;
        chk("B_pushl", {mem_addr, mem_wdata, mem_we}, {16'h0100, 8'h00, 1'b1});
        tick();
        chk("B_pushh", {mem_addr, mem_wdata, sp_new}, {16'h00FF, 8'h02, 16'h00FE});
        tick();
        chk("B_jump", {pc_overwrite, pc_new, tifr_clear}, {1'b1, 14'h00C, 8'h10});
        tifr = 8'h82; timsk = 8'hFF; sreg_i = 1'b0;
        tick();
        pulse_boundary(1'b0);
        chk("B_handler_no_nest", busy, 1'b0);

        sp = 16'h00FE;
        pulse_boundary(1'b1);
        chk("B_poph", {mem_addr, mem_re}, {16'h00FF, 1'b1});
        tick(); tick(); tick();
        chk("B_ret", {pc_overwrite, pc_new, sp_new, sreg_i_set}, {1'b1, 14'h0200, 16'h0100, 1'b1});
        sreg_i = 1'b1;
        tick();

        // One instruction must complete after RETI before re-entry
        pc = 14'h0201; sp = 16'h0000;
        pulse_boundary(1'b0);
        chk("B_guard_blocks", {busy, mem_we}, 2'b00);
        pulse_boundary(1'b0);
        chk("W_pushl_wrap", {busy, mem_addr, mem_wdata, mem_we}, {1'b1, 16'h0000, 8'h01, 1'b1});
        tick();
        chk("W_pushh_wrap", {mem_addr, mem_wdata, sp_we, sp_new}, {16'hFFFF, 8'h02, 1'b1, 16'hFFFE});
        tick();
        chk("W_jump", {pc_new, tifr_clear, sreg_i_clear}, {14'h006, 8'h80, 1'b1});
        tifr = 8'h02;
        tick();

        // RETI wins over a pending source; pop addresses wrap from 0xFFFF
        sp = 16'hFFFF;
        pulse_boundary(1'b1);
        chk("C_poph_wrap", {mem_addr, mem_re, mem_we}, {16'h0000, 1'b1, 1'b0});
        tick();
        chk("C_popl_wrap", {mem_addr, mem_re}, {16'h0001, 1'b1});
        tick(); tick();
        chk("C_ret_wrap", {pc_new, sp_new, sp_we}, {14'h0134, 16'h0001, 1'b1});
        tick();
        pulse_boundary(1'b0);
        chk("C_guard_blocks", busy, 1'b0);

        // Reset in the middle of a push
        pulse_boundary(1'b0);
        tick();
        chk("D_in_pushh", {sp_we, mem_we}, 2'b11);
        rst = 1'b1;
        #1;
        chk("D_rst_masks_outputs", all_outs, 70'd0);
        tick();
        chk("D_rst_idle", all_outs, 70'd0);
        rst = 1'b0;
        tick();
        chk("D_after_rst", all_outs, 70'd0);
        pulse_boundary(1'b0);
        tick(); tick();
        chk("D_reentry_jump", {pc_overwrite, pc_new, tifr_clear}, {1'b1, 14'h012, 8'h02});
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/interrupt_controller.md
INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 The module SHALL have parameter VEC_BASE, default 14'h006, the word address of the highest-priority timer vector (TIFR bit 7).
REQ-002 The module SHALL have parameter VEC_STEP, default 14'h002, the word spacing between consecutive vectors.
REQ-003 Port clk, input, 1: system clock (sysClock domain); all logic SHALL be clocked on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port tifr, input, 8: timer interrupt flags (OCF2, TOV2, ICF1, OCF1A, OCF1B, TOV1, OCF0, TOV0 in bit order 7..0).
REQ-006 Port timsk, input, 8: interrupt mask, with the same bit order as tifr.
REQ-007 Port sreg_i, input, 1: SREG global interrupt enable bit.
REQ-008 Port instr_boundary, input, 1: one-cycle pulse marking that the current instruction has completed.
REQ-009 Port reti, input, 1: qualified by instr_boundary; the completed instruction was RETI.
REQ-010 Port pc, input, 14: return address (next PC).
REQ-011 Port sp, input, 16: current stack pointer.
REQ-012 Port mem_rdata, input, 8: data memory read data, valid one cycle after mem_re.
REQ-013 Port mem_addr, output, 16: data memory address.
REQ-014 Port mem_wdata, output, 8: data memory write data.
REQ-015 Port mem_we, output, 1: data memory write enable.
REQ-016 Port mem_re, output, 1: data memory read enable.
REQ-017 Port sp_we, output, 1: stack pointer write enable.
REQ-018 Port sp_new, output, 16: new stack pointer value.
REQ-019 Port hold, output, 1: stalls program memory fetch and the PC.
REQ-020 Port pc_overwrite, output, 1: loads pc_new into the PC.
REQ-021 Port pc_new, output, 14: vector address or return address.
REQ-022 Port tifr_clear, output, 8: one-hot, one-cycle flag-clear pulse.
REQ-023 Port sreg_i_clear, output, 1: clears SREG I.
REQ-024 Port sreg_i_set, output, 1: sets SREG I.
REQ-025 Port busy, output, 1: high whenever the FSM is not in IDLE.

Function
REQ-026 pending SHALL equal tifr & timsk; the selected source SHALL be the highest set bit of pending (bit 7 highest priority).
REQ-027 The vector address SHALL be VEC_BASE + (7 - idx) * VEC_STEP, truncated to 14 bits.
REQ-028 FSM states SHALL be IDLE, PUSH_L, PUSH_H, JUMP, POP_H, POP_L, POP_W, RET.
REQ-029 In IDLE, if instr_boundary & reti, the FSM SHALL go to POP_H; this takes precedence over a pending interrupt.
REQ-030 In IDLE, if instr_boundary & !reti & sreg_i & |pending & !guard, the FSM SHALL latch pc, sp and idx, then go to PUSH_L.
REQ-031 PUSH_L: mem_addr = sp_l, mem_wdata = pc_l[7:0], mem_we = 1.
REQ-032 PUSH_H: mem_addr = sp_l - 1, mem_wdata = {2'b00, pc_l[13:8]}, mem_we = 1, sp_we = 1, sp_new = sp_l - 2.
REQ-033 JUMP: pc_overwrite = 1, pc_new = vector, tifr_clear = one-hot(idx), sreg_i_clear = 1; the FSM SHALL then return to IDLE.
REQ-034 POP_H: mem_addr = sp_l + 1, mem_re = 1. POP_L: mem_addr = sp_l + 2, mem_re = 1, and the high byte is captured from mem_rdata. POP_W: the low byte is captured.
REQ-035 RET: pc_overwrite = 1, pc_new = {hi[5:0], lo}, sp_we = 1, sp_new = sp_l + 2, sreg_i_set = 1; the FSM SHALL set guard and then go to IDLE.
REQ-036 guard SHALL clear on the next instr_boundary, so that exactly one instruction executes after RETI before another entry.
REQ-037 hold SHALL be 1 in every state except IDLE; interrupt entry latency from the boundary pulse to pc_overwrite SHALL be 3 cycles, and return latency SHALL be 4 cycles.
REQ-038 Stack address arithmetic SHALL be 16-bit modulo: sp = 16'h0000 pushes wrap to 16'hFFFF/16'hFFFE, and sp = 16'hFFFF pops wrap to 0000/0001.
REQ-039 idx SHALL be latched in IDLE; flag or mask changes during entry SHALL NOT alter the vector or tifr_clear.
REQ-040 A new source arriving during entry SHALL remain pending and be serviced after the handler's RETI plus one instruction.
REQ-041 instr_boundary and reti SHALL be ignored while busy.
REQ-042 If pending = 0 or sreg_i = 0 at a boundary, the FSM SHALL take no action.

Reset
REQ-043 When rst is high on a clock edge, the FSM SHALL return to IDLE and guard and all latches SHALL clear, including mid-operation.
REQ-044 Every output SHALL be 0 during and after reset, including mem_addr, sp_new and pc_new; no partial tifr_clear or sp_we pulse SHALL be issued.

Structure
REQ-045 The state enum, VEC_BASE/VEC_STEP defaults and TIFR bit-index constants SHALL live in the shared package avr_pkg.
REQ-046 There SHALL be one sub-module, irq_priority_encoder: 8-bit pending in; valid and 3-bit idx out; combinational.

Verification
REQ-047 tifr = 0x01, timsk = 0x01, sreg_i = 1, pc = 0x0123, sp = 0x085F, boundary pulse -> writes [0x085F] = 0x23, [0x085E] = 0x01; sp_new = 0x085D; pc_new = 0x014; tifr_clear = 0x01; sreg_i_clear at cycle 3.
REQ-048 tifr = 0x12, timsk = 0xFF -> OCF1A is selected, pc_new = 0x00C, tifr_clear = 0x10; the second source is serviced only after RETI plus one boundary.
REQ-049 RETI with sp = 0x085D, memory [0x085E] = 0x01, [0x085F] = 0x23 -> pc_new = 0x0123, sp_new = 0x085F, sreg_i_set; an interrupt still pending is not entered until the second boundary.
REQ-050 sp = 0x0000 push -> addresses 0x0000 and 0xFFFF, sp_new = 0xFFFE; masked flag (timsk = 0) or sreg_i = 0 -> no activity.
REQ-051 rst asserted in PUSH_H -> next cycle IDLE, all outputs 0, no sp_we or tifr_clear.
